// File: rtl/axis_differentiator_v2.sv
`default_nettype none
// ============================================================================
// Module      : axis_differentiator_v2
// Description : AXI4-Stream signed differentiator with bypass, first, central
//               and wideband 5-tap modes, warm-up blanking and sticky overflow.
//               Macro AXIS_DIFFERENTIATOR_SATURATE_EN: clamp instead of wrap.
// Revision    : 2.0
// ============================================================================
module axis_differentiator_v2 #(
    parameter int AXIS_TDATA_WIDTH  = 32,
    parameter bit WARMUP_EN_DEFAULT = 1'b1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [1:0]                  mode,
    input  logic                        clear,
    output logic                        overflow,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    input  logic                        M_AXIS_tready
);

    localparam int c_AW = AXIS_TDATA_WIDTH + 3;
    localparam logic signed [c_AW-1:0] c_MAX_POS = {4'b0000, {(AXIS_TDATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_AW-1:0] c_MIN_NEG = {4'b1111, {(AXIS_TDATA_WIDTH-1){1'b0}}};
    localparam logic [2:0]             c_CNT_SAT = 3'd4;

    logic [AXIS_TDATA_WIDTH-1:0] r_x1, r_x2, r_x3, r_x4;
    logic [1:0]                  r_prev_mode;
    logic [2:0]                  r_warm_cnt;
    logic                        r_warmup_en;
    logic                        r_m_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] r_m_tdata;
    logic                        r_overflow;

    logic                        w_accept;
    logic                        w_mode_change;
    logic signed [c_AW-1:0]      w_x, w_h1, w_h2, w_h3, w_h4;
    logic signed [c_AW-1:0]      w_s1, w_s2, w_d2, w_y_full, w_y;
    logic [2:0]                  w_depth, w_cnt_eff, w_cnt_next;
    logic                        w_blank;
    logic                        w_oor;
    logic [AXIS_TDATA_WIDTH-1:0] w_y_out;

    assign S_AXIS_tready = aresetn & (~r_m_tvalid | M_AXIS_tready);
    assign w_accept      = S_AXIS_tvalid & S_AXIS_tready;
    assign w_mode_change = (mode != r_prev_mode);

    // A mode change makes the beat see an all-zero history.
    assign w_x  = {{3{S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}}, S_AXIS_tdata};
    assign w_h1 = w_mode_change ? '0 : {{3{r_x1[AXIS_TDATA_WIDTH-1]}}, r_x1};
    assign w_h2 = w_mode_change ? '0 : {{3{r_x2[AXIS_TDATA_WIDTH-1]}}, r_x2};
    assign w_h3 = w_mode_change ? '0 : {{3{r_x3[AXIS_TDATA_WIDTH-1]}}, r_x3};
    assign w_h4 = w_mode_change ? '0 : {{3{r_x4[AXIS_TDATA_WIDTH-1]}}, r_x4};

    always_comb begin
        w_s1     = w_h4 - w_x;
        w_s2     = w_h3 - w_h1;
        w_d2     = w_x - w_h2;
        w_y_full = w_x;
        w_depth  = 3'd0;
        case (mode)
            2'd0: begin
                w_y_full = w_x;
                w_depth  = 3'd0;
            end
            2'd1: begin
                w_y_full = w_x - w_h1;
                w_depth  = 3'd1;
            end
            2'd2: begin
                w_y_full = w_d2 >>> 1;
                w_depth  = 3'd2;
            end
            default: begin
                w_y_full = (w_s1 >>> 3) + (w_s1 >>> 4) + w_s2 - (w_s2 >>> 5);
                w_depth  = 3'd4;
            end
        endcase
    end

    assign w_cnt_eff  = w_mode_change ? 3'd0 : r_warm_cnt;
    assign w_cnt_next = (w_cnt_eff >= c_CNT_SAT) ? c_CNT_SAT : w_cnt_eff + 3'd1;
    assign w_blank    = r_warmup_en & (w_cnt_eff < w_depth);
    assign w_y        = w_blank ? '0 : w_y_full;
    assign w_oor      = (w_y > c_MAX_POS) || (w_y < c_MIN_NEG);

`ifdef AXIS_DIFFERENTIATOR_SATURATE_EN
    assign w_y_out = !w_oor          ? w_y[AXIS_TDATA_WIDTH-1:0] :
                     w_y[c_AW-1]     ? c_MIN_NEG[AXIS_TDATA_WIDTH-1:0] :
                                       c_MAX_POS[AXIS_TDATA_WIDTH-1:0];
`else
    assign w_y_out = w_y[AXIS_TDATA_WIDTH-1:0];
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_x4        <= '0;
            r_prev_mode <= 2'd0;
            r_warm_cnt  <= 3'd0;
            r_warmup_en <= WARMUP_EN_DEFAULT;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x1        <= S_AXIS_tdata;
                r_x2        <= w_mode_change ? '0 : r_x1;
                r_x3        <= w_mode_change ? '0 : r_x2;
                r_x4        <= w_mode_change ? '0 : r_x3;
                r_prev_mode <= mode;
                r_warm_cnt  <= w_cnt_next;
                r_m_tvalid  <= 1'b1;
                r_m_tdata   <= w_y_out;
            end else if (M_AXIS_tready) begin
                r_m_tvalid  <= 1'b0;
            end
            // Set has priority over clear.
            if (w_accept && w_oor) begin
                r_overflow <= 1'b1;
            end else if (clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign M_AXIS_tvalid = r_m_tvalid;
    assign M_AXIS_tdata  = r_m_tdata;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: doc/axis_differentiator_v2.md
AXIS_DIFFERENTIATOR_V2 -- requirements
Module: axis_differentiator_v2

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning signed sample width of input and output (legal 8..32).
REQ-002 SHALL have parameter WARMUP_EN_DEFAULT, default 1, meaning reset value of warm-up blanking (1 = blank outputs until history is full).
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port aresetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port mode  input  2  filter select: 0 bypass, 1 first difference, 2 central difference, 3 wideband 5-tap.
REQ-006 SHALL have port clear  input  1  one-cycle pulse that clears the overflow flag.
REQ-007 SHALL have port overflow  output  1  sticky flag, set when any result exceeded the output range.
REQ-008 SHALL have port S_AXIS_tvalid / S_AXIS_tdata / S_AXIS_tready  in / in / out  1 / AXIS_TDATA_WIDTH / 1  AXI4-Stream slave.
REQ-009 SHALL have port M_AXIS_tvalid / M_AXIS_tdata / M_AXIS_tready  out / out / in  1 / AXIS_TDATA_WIDTH / 1  AXI4-Stream master.

Function
REQ-010 A beat SHALL be accepted only when S_AXIS_tvalid and S_AXIS_tready are both high; the 4-deep history x[n-1..n-4] SHALL shift only on acceptance.
REQ-011 S_AXIS_tready SHALL equal aresetn AND (NOT M_AXIS_tvalid OR M_AXIS_tready), giving a single output register with full throughput and no combinational tvalid-to-tready path.
REQ-012 Latency SHALL be exactly 1 cycle: a beat accepted on edge k appears on M_AXIS_tdata with M_AXIS_tvalid high after edge k.
REQ-013 M_AXIS_tvalid SHALL clear on the edge where M_AXIS_tready is high and no new beat is accepted. M_AXIS_tdata SHALL hold while tvalid is high and tready is low.
REQ-014 All arithmetic SHALL be signed, at AXIS_TDATA_WIDTH+3 bits. Shifts SHALL be arithmetic (floor).
REQ-015 mode 0: y = x[n]. mode 1: y = x[n] - x[n-1]. mode 2: y = (x[n] - x[n-2]) >>> 1.
REQ-016 mode 3: with s1 = x[n-4] - x[n] and s2 = x[n-3] - x[n-1], y = (s1>>>3) + (s1>>>4) + s2 - (s2>>>5).
REQ-017 mode SHALL be sampled per accepted beat. A beat whose mode differs from the previous accepted beat's mode SHALL be treated as follows:
- the history SHALL be zeroed before use, so the beat sees only itself;
- the warm-up counter SHALL restart.
REQ-018 Warm-up: with blanking enabled, the first D outputs after reset or a mode change SHALL be 0, where D is 0, 1, 2, 4 for modes 0..3. The counter SHALL saturate at 4.
REQ-019 overflow SHALL set on any output beat whose full-width y lies outside the AXIS_TDATA_WIDTH signed range. clear SHALL reset it. If set and clear occur in the same cycle, set SHALL win.
REQ-020 The block SHALL never drop or duplicate a beat under any tvalid/tready pattern.

Reset
REQ-021 With aresetn low on an edge, the following SHALL be zero: history, output register, M_AXIS_tvalid, overflow, warm-up counter and stored previous mode.
REQ-022 S_AXIS_tready SHALL be low while aresetn is low. A reset asserted mid-transfer SHALL discard the pending output beat.
REQ-023 Warm-up blanking SHALL initialise from WARMUP_EN_DEFAULT.

Configuration
REQ-024 Macro AXIS_DIFFERENTIATOR_SATURATE_EN SHALL control out-of-range handling.
- Defined: out-of-range y SHALL clamp to max positive / max negative of AXIS_TDATA_WIDTH.
- Undefined: y SHALL wrap (take the low AXIS_TDATA_WIDTH bits).
- overflow behaviour SHALL be identical in both builds.

Verification (AXIS_TDATA_WIDTH=16, M_AXIS_tready=1 unless stated)
REQ-025 Stimulus: mode 1, warm-up off, ramp 0,10,20,30. Required: outputs 0,10,10,10, each 1 cycle after acceptance.
REQ-026 Stimulus: mode 3, warm-up on, constant 100 for 8 beats. Required: first 4 outputs 0, then 0. Stimulus: ramp 0,32,64,96,128,160. Required: beats 5-6 equal (-128>>>3)+(-128>>>4)+(-64)-(-64>>>5) = -16-8-64+2 = -86.
REQ-027 Stimulus: mode 1, inputs 32767 then -32768. Required: overflow sets. Saturate build outputs -32768; wrap build outputs 1. A clear pulse then drops the flag.
REQ-028 Stimulus: M_AXIS_tready toggled randomly, S_AXIS_tvalid held high with a counting sequence. Required: output sequence is complete and in order, tdata stable while stalled, S_AXIS_tready low only when the output is full and stalled.
REQ-029 Stimulus: mode switched 1->2 mid-stream. Required: first mode-2 output equals (x[n]>>>1) with blanking off, or 0 with blanking on.
REQ-030 Stimulus: aresetn pulsed low for 1 cycle while M_AXIS_tvalid is high and stalled. Required: M_AXIS_tvalid low next cycle, overflow 0, and the next output is computed from zero history.
